ddr_read_arbiter: RTL and testbench
===================================

# ddr_read_arbiter

Parametrised N-channel arbiter between the DDR read requesters (bias, weight and feature-data fill controllers) and the single DDR read engine. It replaces the static `switch`-driven DDR mux. Each channel posts a request that is held pending until granted, the winning request is issued to the engine, and the returned beat stream is routed to the owning channel. A channel is released after exactly `len` beats.

## Interface
- N_CH, 3, number of requester channels (2..8)
- DDR_ADDR_LEN, 32, DDR start-address width
- SINGLE_LEN, 24, burst-length width; units are beats of DDR_DATA_LEN bits
- DDR_DATA_LEN, 512, beat width

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ch_st_addr  in  N_CH*DDR_ADDR_LEN  per-channel start address; channel i occupies slice [i*DDR_ADDR_LEN +: DDR_ADDR_LEN]
- ch_len  in  N_CH*SINGLE_LEN  per-channel beat count, packed the same way
- ch_conf  in  N_CH  one-cycle request strobe per channel
- ch_fifo_empty  out  N_CH  per-channel empty flag, as the channel sees it
- ch_fifo_req  in  N_CH  per-channel pop request
- ch_fifo_data  out  DDR_DATA_LEN  beat data, broadcast to all channels
- ch_done  out  N_CH  one-cycle pulse after a channel's last beat
- m_st_addr  out  DDR_ADDR_LEN  start address to the engine
- m_len  out  SINGLE_LEN  beat count to the engine
- m_conf  out  1  one-cycle command strobe to the engine
- m_fifo_empty  in  1  engine FIFO empty flag
- m_fifo_req  out  1  engine FIFO pop
- m_fifo_data  in  DDR_DATA_LEN  engine FIFO data
- grant  out  N_CH  one-hot owner; zero when idle
- busy  out  1  high in ISSUE or STREAM
- err  out  N_CH  sticky per-channel overflow flag

## Operation
- Pending slot per channel, depth 1: captures addr and len on ch_conf.
- Pending clears when the channel is granted.
- A ch_conf in the same cycle as that channel's grant re-arms the slot with the new values.
- A ch_conf while the slot is already pending drops the new request and sets err[i]. The original request is kept.
- FSM states: IDLE, ISSUE, STREAM.
- IDLE → ISSUE when any slot is pending. The arbiter selects the winner, latches it into grant, and loads m_st_addr/m_len.
- ISSUE lasts exactly one cycle with m_conf=1, then moves to STREAM.
- Winner with len=0: no m_conf is issued; ch_done pulses; the FSM returns to IDLE.
- STREAM routing for granted channel g:
  - ch_fifo_empty[g] = m_fifo_empty
  - all other ch_fifo_empty bits = 1
  - m_fifo_req = ch_fifo_req[g] & ~m_fifo_empty
  - ch_fifo_data = m_fifo_data
- Outside STREAM: all ch_fifo_empty bits = 1 and m_fifo_req = 0.
- Beat = m_fifo_req in a cycle. A SINGLE_LEN-bit counter increments per beat.
- On the beat where count == len-1:
  - next cycle: ch_done[g]=1, grant=0, state IDLE
  - any m_fifo_req after the last beat is masked to 0
- Arbitration order comes from the macro below.
- Request latency: the IDLE → ISSUE decision and m_conf for a new request both come from registered state.

## Timing
- Reset values: state IDLE, grant=0, busy=0, m_conf=0, m_st_addr=0, m_len=0, m_fifo_req=0, all ch_fifo_empty=1, ch_done=0, err=0, pending=0, round-robin pointer=0, ch_fifo_data=0.
- Idle arbiter, ch_conf at edge k: grant and busy at k+1, m_conf high during k+2 only.
- Back-to-back requests: m_conf of the next transfer comes 2 cycles after the ch_done of the previous one.
- Data path is combinational from m_fifo_data to ch_fifo_data: zero added latency, no buffering.
- Reset mid-stream takes effect asynchronously:
  - all outputs return to their reset values
  - pending requests and the counter are lost
  - no ch_done is issued
  - the engine FIFO is not drained by this block
- err clears only on reset.

## Configuration
- DDR_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (last granted index + 1) mod N_CH.
  - The pointer updates on every grant, including len=0 grants.
- DDR_ARB_RR_EN undefined: fixed priority, lowest pending index wins, no pointer register.

## Test plan
- Single request, ch1 addr=0x1000 len=4, engine FIFO never empty -> m_conf at k+2 with m_st_addr=0x1000 m_len=4; exactly 4 beats on ch1; ch_done[1] one cycle after the 4th beat; grant returns to 0.
- With DDR_ARB_RR_EN: ch0, ch1, ch2 strobe in the same cycle, len=2 each -> grant order 0, 1, 2. Then re-request ch0 and ch2 -> order continues 0, 2 (pointer at 0 after ch2).
- Without DDR_ARB_RR_EN: ch2 and ch0 strobe together, then ch1 posts during ch0's stream -> order 0, 1, 2.
- ch0 len=0 -> no m_conf; ch_done[0] pulses 2 cycles after ch_conf; busy goes high for one cycle only.
- ch1 strobed twice while pending, during ch0's len=8 stream -> err[1]=1, only the first ch1 addr is issued, err[1] remains 1 afterwards.
- rst asserted after beat 2 of a len=6 transfer with m_fifo_empty toggling -> all outputs reset immediately, no ch_done; a new ch0 request after reset is issued normally.

Source files
------------

// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter: N-channel arbiter in front of the single DDR read engine.
// Define DDR_ARB_RR_EN for round-robin; otherwise the lowest pending index wins.
module ddr_read_arbiter #(
    parameter int N_CH         = 3,
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int DDR_DATA_LEN = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH*DDR_ADDR_LEN-1:0] ch_st_addr,
    input  logic [N_CH*SINGLE_LEN-1:0]   ch_len,
    input  logic [N_CH-1:0]              ch_conf,
    output logic [N_CH-1:0]              ch_fifo_empty,
    input  logic [N_CH-1:0]              ch_fifo_req,
    output logic [DDR_DATA_LEN-1:0]      ch_fifo_data,
    output logic [N_CH-1:0]              ch_done,
    output logic [DDR_ADDR_LEN-1:0]      m_st_addr,
    output logic [SINGLE_LEN-1:0]        m_len,
    output logic                         m_conf,
    input  logic                         m_fifo_empty,
    output logic                         m_fifo_req,
    input  logic [DDR_DATA_LEN-1:0]      m_fifo_data,
    output logic [N_CH-1:0]              grant,
    output logic                         busy,
    output logic [N_CH-1:0]              err
);

    localparam int IW = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM
    } state_e;

    state_e                  state_q, state_d;
    logic [N_CH-1:0]         pend_q;
    logic [N_CH-1:0]         err_q;
    logic [DDR_ADDR_LEN-1:0] slot_addr_q [N_CH];
    logic [SINGLE_LEN-1:0]   slot_len_q  [N_CH];
    logic [N_CH-1:0]         grant_q;
    logic [IW-1:0]           gidx_q;
    logic [DDR_ADDR_LEN-1:0] m_st_addr_q;
    logic [SINGLE_LEN-1:0]   m_len_q;
    logic                    m_conf_q;
    logic [N_CH-1:0]         ch_done_q;
    logic [SINGLE_LEN-1:0]   cnt_q;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic          grant_now;
    logic          last_beat;
    logic          zero_len;

`ifdef DDR_ARB_RR_EN
    // ptr_q holds the index where the next search starts
    logic [IW-1:0] ptr_q;

    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int j = 0; j < N_CH; j++) begin
            idx = (int'(ptr_q) + j) % N_CH;
            if (!win_vld && pend_q[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_now) begin
            ptr_q <= (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (!win_vld && pend_q[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end
`endif

    assign grant_now = (state_q == IDLE) && win_vld;
    assign zero_len  = (m_len_q == '0);
    assign last_beat = m_fifo_req && (cnt_q == m_len_q - SINGLE_LEN'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_vld) state_d = ISSUE;
            ISSUE:   state_d = zero_len ? IDLE : STREAM;
            STREAM:  if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Routing is purely combinational so beats see no added latency
    always_comb begin
        ch_fifo_empty = '1;
        m_fifo_req    = 1'b0;
        ch_fifo_data  = '0;
        if (state_q == STREAM) begin
            ch_fifo_empty[gidx_q] = m_fifo_empty;
            m_fifo_req            = ch_fifo_req[gidx_q] & ~m_fifo_empty;
            ch_fifo_data          = m_fifo_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            err_q       <= '0;
            grant_q     <= '0;
            gidx_q      <= '0;
            m_st_addr_q <= '0;
            m_len_q     <= '0;
            m_conf_q    <= 1'b0;
            ch_done_q   <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_addr_q[i] <= '0;
                slot_len_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            m_conf_q  <= (state_q == ISSUE) && !zero_len;
            ch_done_q <= '0;

            for (int i = 0; i < N_CH; i++) begin
                if (ch_conf[i]) begin
                    if (pend_q[i] && !(grant_now && win_idx == IW'(i))) begin
                        err_q[i] <= 1'b1;
                    end else begin
                        pend_q[i]      <= 1'b1;
                        slot_addr_q[i] <= ch_st_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                        slot_len_q[i]  <= ch_len[i*SINGLE_LEN +: SINGLE_LEN];
                    end
                end else if (grant_now && win_idx == IW'(i)) begin
                    pend_q[i] <= 1'b0;
                end
            end

            if (grant_now) begin
                grant_q     <= N_CH'(1) << win_idx;
                gidx_q      <= win_idx;
                m_st_addr_q <= slot_addr_q[win_idx];
                m_len_q     <= slot_len_q[win_idx];
            end

            if (state_q == ISSUE) begin
                cnt_q <= '0;
                if (zero_len) begin
                    ch_done_q <= grant_q;
                    grant_q   <= '0;
                end
            end

            if (state_q == STREAM && m_fifo_req) begin
                cnt_q <= cnt_q + 1'b1;
                if (last_beat) begin
                    ch_done_q <= grant_q;
                    grant_q   <= '0;
                end
            end
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign m_conf    = m_conf_q;
    assign m_st_addr = m_st_addr_q;
    assign m_len     = m_len_q;
    assign ch_done   = ch_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Scoreboard bench for ddr_read_arbiter: commands, beats and done pulses
// are queued by the stimulus and checked by a negedge monitor.
module tb_ddr_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 24;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] ch_st_addr = '0;
    logic [N*LW-1:0] ch_len = '0;
    logic [N-1:0]    ch_conf = '0;
    logic [N-1:0]    ch_fifo_empty;
    logic [N-1:0]    ch_fifo_req = '1;
    logic [DW-1:0]   ch_fifo_data;
    logic [N-1:0]    ch_done;
    logic [AW-1:0]   m_st_addr;
    logic [LW-1:0]   m_len;
    logic            m_conf;
    logic            m_fifo_empty = 1'b0;
    logic            m_fifo_req;
    logic [DW-1:0]   m_fifo_data = '0;
    logic [N-1:0]    grant;
    logic            busy;
    logic [N-1:0]    err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [N-1:0]  gnt;
    } cmd_t;

    cmd_t         exp_cmd[$];
    int           exp_beat[$];
    logic [N-1:0] exp_done[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          beats_seen = 0;
    logic        toggle_en = 1'b0;
    logic [31:0] dword = 32'h1;

    ddr_read_arbiter #(
        .N_CH(N), .DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DDR_DATA_LEN(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_st_addr(ch_st_addr), .ch_len(ch_len), .ch_conf(ch_conf),
        .ch_fifo_empty(ch_fifo_empty), .ch_fifo_req(ch_fifo_req),
        .ch_fifo_data(ch_fifo_data), .ch_done(ch_done),
        .m_st_addr(m_st_addr), .m_len(m_len), .m_conf(m_conf),
        .m_fifo_empty(m_fifo_empty), .m_fifo_req(m_fifo_req),
        .m_fifo_data(m_fifo_data), .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a,
                          input logic [LW-1:0] l);
        ch_st_addr[i*AW +: AW] = a;
        ch_len[i*LW +: LW]     = l;
    endtask

    task automatic push_xfer(input int ch, input logic [AW-1:0] a,
                             input logic [LW-1:0] l);
        cmd_t c;
        if (l != 0) begin
            c.addr = a;
            c.len  = l;
            c.gnt  = N'(1 << ch);
            exp_cmd.push_back(c);
            for (int b = 0; b < int'(l); b++) exp_beat.push_back(ch);
        end
        exp_done.push_back(N'(1 << ch));
    endtask

    // Returns 1 ns after the edge that samples the strobe
    task automatic strobe(input logic [N-1:0] m);
        @(posedge clk); #1;
        ch_conf = m;
        @(posedge clk); #1;
        ch_conf = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_drained(input string nm);
        chk({nm, "_cmd_left"}, 64'(exp_cmd.size()), 0);
        chk({nm, "_beat_left"}, 64'(exp_beat.size()), 0);
        chk({nm, "_done_left"}, 64'(exp_done.size()), 0);
    endtask

    // Monitor: compares every DUT event against the queues, then drives
    // the engine-side FIFO for the next cycle.
    initial begin
        cmd_t         e;
        int           c;
        logic [N-1:0] oh;
        logic [N-1:0] noh;
        forever begin
            @(negedge clk);
            if (m_conf) begin
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_m_conf", {32'h0, m_st_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_addr", m_st_addr, e.addr);
                    chk("cmd_len", m_len, e.len);
                    chk("cmd_grant", grant, e.gnt);
                end
            end
            if (m_fifo_req) begin
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    chk("unexpected_beat", grant, 0);
                    chk("unexpected_beat_req", m_fifo_req, 0);
                end else begin
                    c   = exp_beat.pop_front();
                    oh  = N'(1 << c);
                    noh = ~oh;
                    chk("beat_grant", grant, oh);
                    chk("beat_empty", ch_fifo_empty, noh);
                    chk("beat_data", ch_fifo_data[63:0], m_fifo_data[63:0]);
                    chk("beat_data_hi", ch_fifo_data[DW-1:DW-64], m_fifo_data[DW-1:DW-64]);
                end
            end
            if (ch_done != '0) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", ch_done, 0);
                end else begin
                    oh = exp_done.pop_front();
                    chk("done_ch", ch_done, oh);
                end
            end
            if (m_fifo_req) begin
                dword       = dword + 32'h0101_0101;
                m_fifo_data = {16{dword}};
            end
            m_fifo_empty = toggle_en ? ~m_fifo_empty : 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int waited;
        m_fifo_data = {16{dword}};

        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_conf", m_conf, 0);
        chk("rst_m_req", m_fifo_req, 0);
        chk("rst_empty", ch_fifo_empty, 3'b111);
        chk("rst_done", ch_done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", m_st_addr, 0);
        chk("rst_len", m_len, 0);
        chk("rst_data", ch_fifo_data[63:0], 0);
        cyc(3);
        rst = 1'b0;
        cyc(2);

`ifdef DDR_ARB_RR_EN
        set_ch(0, 32'hA000, 2);
        set_ch(1, 32'hA100, 2);
        set_ch(2, 32'hA200, 2);
        push_xfer(0, 32'hA000, 2);
        push_xfer(1, 32'hA100, 2);
        push_xfer(2, 32'hA200, 2);
        strobe(3'b111);
        cyc(30);
        chk_drained("rr_a");
        set_ch(0, 32'hB000, 2);
        set_ch(2, 32'hB200, 2);
        push_xfer(0, 32'hB000, 2);
        push_xfer(2, 32'hB200, 2);
        strobe(3'b101);
        cyc(25);
        chk_drained("rr_b");
`else
        set_ch(0, 32'hA000, 2);
        set_ch(2, 32'hA200, 2);
        push_xfer(0, 32'hA000, 2);
        push_xfer(1, 32'hA100, 2);
        push_xfer(2, 32'hA200, 2);
        strobe(3'b101);
        cyc(1);
        chk("fp_grant0", grant, 3'b001);
        set_ch(1, 32'hA100, 2);
        ch_conf = 3'b010;
        cyc(1);
        ch_conf = '0;
        chk("fp_mconf0", m_conf, 1);
        cyc(2);
        chk("fp_done0", ch_done, 3'b001);
        cyc(2);
        chk("fp_b2b_mconf", m_conf, 1);
        chk("fp_grant1", grant, 3'b010);
        cyc(20);
        chk_drained("fp");
`endif

        set_ch(1, 32'h1000, 4);
        push_xfer(1, 32'h1000, 4);
        strobe(3'b010);
        chk("s_grant_k", grant, 0);
        cyc(1);
        chk("s_grant_k1", grant, 3'b010);
        chk("s_busy_k1", busy, 1);
        chk("s_mconf_k1", m_conf, 0);
        chk("s_addr_k1", m_st_addr, 32'h1000);
        chk("s_len_k1", m_len, 4);
        cyc(1);
        chk("s_mconf_k2", m_conf, 1);
        cyc(1);
        chk("s_mconf_k3", m_conf, 0);
        cyc(3);
        chk("s_done_k6", ch_done, 3'b010);
        chk("s_grant_k6", grant, 0);
        cyc(1);
        chk("s_done_k7", ch_done, 0);
        cyc(4);
        chk_drained("single");

        set_ch(0, 32'h0700, 0);
        push_xfer(0, 32'h0700, 0);
        strobe(3'b001);
        cyc(1);
        chk("z_busy_k1", busy, 1);
        chk("z_grant_k1", grant, 3'b001);
        cyc(1);
        chk("z_done_k2", ch_done, 3'b001);
        chk("z_busy_k2", busy, 0);
        chk("z_grant_k2", grant, 0);
        cyc(1);
        chk("z_mconf_k3", m_conf, 0);
        chk("z_busy_k3", busy, 0);
        cyc(3);
        chk_drained("zero");

        set_ch(0, 32'h6000, 8);
        push_xfer(0, 32'h6000, 8);
        push_xfer(1, 32'h2000, 1);
        strobe(3'b001);
        cyc(1);
        set_ch(1, 32'h2000, 1);
        ch_conf = 3'b010;
        cyc(1);
        ch_conf = '0;
        set_ch(1, 32'h3000, 3);
        cyc(1);
        ch_conf = 3'b010;
        cyc(1);
        ch_conf = '0;
        chk("e_err_set", err, 3'b010);
        cyc(20);
        chk("e_err_kept", err, 3'b010);
        chk("e_grant_idle", grant, 0);
        chk_drained("err");

        set_ch(0, 32'h4000, 6);
        begin
            cmd_t c;
            c.addr = 32'h4000;
            c.len  = 6;
            c.gnt  = 3'b001;
            exp_cmd.push_back(c);
            exp_beat.push_back(0);
            exp_beat.push_back(0);
        end
        toggle_en = 1'b1;
        waited    = 0;
        beats_seen = 0;
        strobe(3'b001);
        while (beats_seen < 2 && waited < 40) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("r_beats_reached", 64'(beats_seen >= 2), 1);
        rst = 1'b1;
        #1;
        chk("r_grant", grant, 0);
        chk("r_busy", busy, 0);
        chk("r_mconf", m_conf, 0);
        chk("r_mreq", m_fifo_req, 0);
        chk("r_empty", ch_fifo_empty, 3'b111);
        chk("r_done", ch_done, 0);
        chk("r_err", err, 0);
        chk("r_addr", m_st_addr, 0);
        chk("r_len", m_len, 0);
        chk("r_data", ch_fifo_data[63:0], 0);
        toggle_en = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("r_no_done", ch_done, 0);
        chk("r_idle", busy, 0);

        set_ch(0, 32'h5000, 2);
        push_xfer(0, 32'h5000, 2);
        strobe(3'b001);
        cyc(2);
        chk("r2_mconf", m_conf, 1);
        chk("r2_addr", m_st_addr, 32'h5000);
        cyc(10);
        chk_drained("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
